// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - program-memory fetch and ALU opcode/operand/status bus
interface alu_sequencer_if #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3,
  parameter int AddrWidth     = 8
);
  logic [AddrWidth-1:0]     imem_addr;
  logic                     imem_req;
  logic                     imem_ack;
  logic [15:0]              imem_data;
  logic [NumOpCodeBits-1:0] alu_opcode;
  logic [DataWidth-1:0]     alu_operand1;
  logic [DataWidth-1:0]     alu_operand2;
  logic [ParamBits-1:0]     alu_param;
  logic [DataWidth-1:0]     alu_result;
  logic [NumStatusBits-1:0] alu_status;

  modport master (
    output imem_addr, imem_req, alu_opcode, alu_operand1, alu_operand2, alu_param,
    input  imem_ack, imem_data, alu_result, alu_status
  );

  modport slave (
    input  imem_addr, imem_req, alu_opcode, alu_operand1, alu_operand2, alu_param,
    output imem_ack, imem_data, alu_result, alu_status
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute control core driving an external 8-bit ALU
module alu_sequencer #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3,
  parameter int AddrWidth     = 8,
  parameter int NumRegs       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_sequencer_if.master          bus,
  output logic [NumStatusBits-1:0] flags,
  output logic [AddrWidth-1:0]     pc,
  output logic                     halted,
  input  logic [2:0]               dbg_sel,
  output logic [DataWidth-1:0]     dbg_data
);
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_VAL = 5'b01000;
  localparam logic [4:0] OP_JMP = 5'b10000;
  localparam logic [4:0] OP_JZ  = 5'b10001;
  localparam logic [4:0] OP_JC  = 5'b10010;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

  state_t               state, state_next;
  logic [15:0]          ir;
  logic [DataWidth-1:0] regs [NumRegs];

  logic [4:0] op;
  logic [2:0] rd, rs;
  logic [7:0] imm;
  logic       is_alu, is_flag_op;
  logic [AddrWidth-1:0] pc_inc, pc_imm;

  assign op         = ir[15:11];
  assign rd         = ir[10:8];
  assign rs         = ir[7:5];
  assign imm        = ir[7:0];
  assign is_alu     = (op >= OP_ADD) && (op <= OP_VAL);
  assign is_flag_op = (op >= OP_ADD) && (op <= OP_SHR);
  assign pc_inc     = pc + AddrWidth'(1);
  assign pc_imm     = AddrWidth'(imm);
  assign dbg_data   = regs[dbg_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (bus.imem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (is_alu)             state_next = S_EXECUTE;
        else if (op == OP_HLT)  state_next = S_HALT;
        else                    state_next = S_FETCH;
      end
      S_EXECUTE: state_next = S_FETCH;
      default:   state_next = S_HALT;
    endcase
  end

  // Request is gated by reset so the bus is quiet while reset is held.
  always_comb begin
    bus.imem_req  = (state == S_FETCH) && !reset;
    bus.imem_addr = pc;
    halted        = (state == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= '0;
      flags            <= '0;
      ir               <= '0;
      bus.alu_opcode   <= NumOpCodeBits'(OP_NOP);
      bus.alu_operand1 <= '0;
      bus.alu_operand2 <= '0;
      bus.alu_param    <= '0;
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (bus.imem_ack) ir <= bus.imem_data;
        S_DECODE: begin
          if (is_alu) begin
            bus.alu_opcode   <= NumOpCodeBits'(op);
            bus.alu_operand1 <= regs[rd];
            bus.alu_operand2 <= regs[rs];
            bus.alu_param    <= ParamBits'(imm);
          end else begin
            case (op)
              OP_JMP:  pc <= pc_imm;
              OP_JZ:   pc <= flags[2] ? pc_imm : pc_inc;
              OP_JC:   pc <= flags[0] ? pc_imm : pc_inc;
              OP_HLT:  pc <= pc;
              default: pc <= pc_inc;
            endcase
          end
        end
        S_EXECUTE: begin
          regs[rd] <= bus.alu_result;
          pc       <= pc_inc;
          // VAL loads a register without disturbing the condition flags.
          if (is_flag_op) flags <= bus.alu_status;
          bus.alu_opcode   <= NumOpCodeBits'(OP_NOP);
          bus.alu_operand1 <= '0;
          bus.alu_operand2 <= '0;
          bus.alu_param    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Instruction sequencer that acts as the initiator for the 8-bit ALU's opcode/operand/status interface. Each cycle sequence fetches a 16-bit instruction from program memory and reads operands from an 8x8 register file. It drives the ALU, captures the result and status, writes the result back, and resolves conditional jumps on the latched flags. It sits between the program memory and the ALU as the control core of the CPU.

Parameters:
DataWidth, 8, register/ALU data width
NumOpCodeBits, 5, ALU opcode width
ParamBits, 8, ALU param width
NumStatusBits, 3, ALU status width
AddrWidth, 8, program counter / instruction address width
NumRegs, 8, register file depth (index width 3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  AddrWidth  instruction address, equals pc
imem_req  out  1  fetch request
imem_ack  in  1  instruction data valid this cycle
imem_data  in  16  instruction word
alu_opcode  out  NumOpCodeBits  ALU opcode
alu_operand1  out  DataWidth  ALU operand 1
alu_operand2  out  DataWidth  ALU operand 2
alu_param  out  ParamBits  ALU param
alu_result  in  DataWidth  ALU result, combinational from ALU
alu_status  in  NumStatusBits  ALU status: [0] carry/overflow, [2] zero
flags  out  NumStatusBits  latched status
pc  out  AddrWidth  program counter
halted  out  1  high in HALT state
dbg_sel  in  3  register-file debug read index
dbg_data  out  DataWidth  R[dbg_sel], combinational

Behaviour:
- The clock is clk. Reset is reset: asynchronous and active-high. There is one clock domain.
- Reset values:
  - pc=0, flags=0, halted=0, imem_req=0.
  - All R[i]=0, IR=0.
  - alu_opcode=NOP (00000), alu_operand1=0, alu_operand2=0, alu_param=0.
  - State=FETCH.
- Instruction format:
  - IR[15:11] = op
  - IR[10:8] = rd
  - IR[7:5] = rs
  - IR[7:0] = imm
- Opcodes:
  - 00000 NOP
  - 00001 ADD, 00010 SUB, 00011 AND, 00100 OR, 00101 NOT, 00110 SHL, 00111 SHR
  - 01000 VAL
  - 10000 JMP, 10001 JZ, 10010 JC
  - 11111 HLT
  - Any other opcode executes as NOP.
- State FETCH:
  - imem_req=1 and imem_addr=pc.
  - On a cycle with imem_ack=1: IR<=imem_data, next state DECODE, imem_req drops in the following cycle.
  - Wait states are unlimited.
  - imem_ack while imem_req=0 is ignored.
- State DECODE:
  - ALU ops (00001–01000): register alu_opcode<=op, alu_operand1<=R[rd], alu_operand2<=R[rs], alu_param<=imm. Next state EXECUTE.
  - JMP: pc<=imm.
  - JZ: pc<=imm if flags[2]=1, else pc+1.
  - JC: pc<=imm if flags[0]=1, else pc+1.
  - NOP/unknown: pc<=pc+1, next state FETCH.
  - HLT: next state HALT, pc unchanged.
- State EXECUTE:
  - Sample alu_result/alu_status at the clock edge ending the cycle. R[rd]<=alu_result; pc<=pc+1.
  - Opcodes 00001–00111: flags<=alu_status.
  - VAL: writes R[rd] and leaves flags unchanged.
  - ALU inputs return to NOP/0/0/0. Next state FETCH.
- ALU inputs hold stable from the DECODE edge through EXECUTE. Outside EXECUTE they are NOP/0/0/0.
- State HALT: halted=1, imem_req=0, no state change until reset.
- Latency:
  - ALU instruction = fetch (1 + wait cycles) + DECODE + EXECUTE = 3 cycles minimum.
  - Jump/NOP = 2 cycles minimum.
- pc arithmetic is modulo 2^AddrWidth: 255+1 wraps to 0.
- rd==rs is legal; the operand is read before the write.
- flags only change in EXECUTE, so JZ/JC test the flags of the most recent flag-updating ALU op.
- Reset asserted mid-fetch or mid-execute aborts immediately to reset values. The pending register write is discarded.

Test Plan:
- VAL R1,3; VAL R2,1; ADD R1,R2, zero-wait memory -> R1=4, flags=000, pc=3. The ADD executes in exactly 3 cycles after its fetch starts.
- VAL R1,255; VAL R2,2; ADD R1,R2 -> R1=1, flags[0]=1. A following JC 0x10 sets pc=0x10; JZ 0x20 at that point falls through to pc+1.
- VAL R3,0xCC; VAL R4,0x33; AND R3,R4 -> R3=0, flags[2]=1. JZ 0x40 is taken (pc=0x40); a following VAL does not clear flags[2].
- NOT R5,R6 with R6=0xAC -> alu_operand2=0xAC during EXECUTE, R5 takes alu_result=0x53. Hold imem_ack low for 5 cycles before this fetch -> imem_req stays high 6 cycles and imem_addr stays constant.
- JMP 0xFF, then at 0xFF a NOP -> pc wraps to 0x00. HLT -> halted=1, imem_req=0 for 20 cycles; imem_ack pulses are ignored.
- Assert reset during an EXECUTE of ADD R1,R2 -> R1 stays 0 and pc=0. ALU outputs go to NOP/0 asynchronously and the next fetch is from address 0.
